// File: rtl/max_q_scheduler.sv
// Max-Q scheduler: reads every action of one Q-table row through the shared read port
// and reports the signed maximum. Define MAX_Q_SCHED_ARGMAX_EN to also report best_action.
module max_q_scheduler #(
   parameter int  DATA_WIDTH  = 32,
   parameter int  ACTIONS     = 4,
   parameter int  STATE_WIDTH = 8,
   localparam int ACT_WIDTH   = $clog2(ACTIONS)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [STATE_WIDTH-1:0]         state_in,
   output logic                           busy,
   output logic                           q_req,
   input  logic                           q_gnt,
   output logic                           q_rd_en,
   output logic [STATE_WIDTH+ACT_WIDTH-1:0] q_addr,
   input  logic [DATA_WIDTH-1:0]          q_rd_data,
   output logic [DATA_WIDTH-1:0]          max_q,
`ifdef MAX_Q_SCHED_ARGMAX_EN
   output logic [ACT_WIDTH-1:0]           best_action,
`endif
   output logic                           done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   // One extra counter bit so a count of ACTIONS never wraps to zero for power-of-two rows.
   localparam int             CNT_W    = ACT_WIDTH + 1;
   localparam logic [CNT_W-1:0] NUM_ACT  = CNT_W'(ACTIONS);
   localparam logic [CNT_W-1:0] LAST_ACT = CNT_W'(ACTIONS - 1);

   logic [1:0]                    fsmState_q, fsmState_d;
   logic [STATE_WIDTH-1:0]        latState_q, latState_d;
   logic [CNT_W-1:0]              issueCnt_q, issueCnt_d;
   logic [CNT_W-1:0]              recvCnt_q, recvCnt_d;
   logic                          first_q, first_d;
   logic                          rdValid_q;
   logic signed [DATA_WIDTH-1:0]  accVal_q, accVal_d;
   logic [DATA_WIDTH-1:0]         maxQ_q, maxQ_d;
`ifdef MAX_Q_SCHED_ARGMAX_EN
   logic [ACT_WIDTH-1:0]          runIdx_q, runIdx_d;
   logic [ACT_WIDTH-1:0]          bestIdx_q, bestIdx_d;
`endif

   assign busy    = (fsmState_q != IDLE);
   assign done    = (fsmState_q == DONE);
   assign q_req   = (fsmState_q == ISSUE);
   assign q_rd_en = q_req && q_gnt && (issueCnt_q < NUM_ACT);
   assign q_addr  = {latState_q, issueCnt_q[ACT_WIDTH-1:0]};
   assign max_q   = maxQ_q;
`ifdef MAX_Q_SCHED_ARGMAX_EN
   assign best_action = bestIdx_q;
`endif

   always_comb begin
      fsmState_d = fsmState_q;
      latState_d = latState_q;
      issueCnt_d = issueCnt_q;
      recvCnt_d  = recvCnt_q;
      first_d    = first_q;
      accVal_d   = accVal_q;
      maxQ_d     = maxQ_q;
`ifdef MAX_Q_SCHED_ARGMAX_EN
      runIdx_d   = runIdx_q;
      bestIdx_d  = bestIdx_q;
`endif

      // Data arrives in issue order, so recvCnt_q is the action index of the current sample.
      if (rdValid_q) begin
         recvCnt_d = recvCnt_q + CNT_W'(1);
         if (first_q || ($signed(q_rd_data) > accVal_q)) begin
            accVal_d = q_rd_data;
            first_d  = 1'b0;
`ifdef MAX_Q_SCHED_ARGMAX_EN
            runIdx_d = recvCnt_q[ACT_WIDTH-1:0];
`endif
         end
      end

      case (fsmState_q)
         IDLE: begin
            if (start) begin
               latState_d = state_in;
               issueCnt_d = '0;
               recvCnt_d  = '0;
               first_d    = 1'b1;
               fsmState_d = ISSUE;
            end
         end
         ISSUE: begin
            if (q_rd_en) begin
               issueCnt_d = issueCnt_q + CNT_W'(1);
               if (issueCnt_q == LAST_ACT) begin
                  fsmState_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Looking at the next-state count lets the last sample finish in the same cycle.
            if (recvCnt_d == NUM_ACT) begin
               maxQ_d     = accVal_d;
`ifdef MAX_Q_SCHED_ARGMAX_EN
               bestIdx_d  = runIdx_d;
`endif
               fsmState_d = DONE;
            end
         end
         default: begin
            fsmState_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsmState_q <= IDLE;
         latState_q <= '0;
         issueCnt_q <= '0;
         recvCnt_q  <= '0;
         first_q    <= 1'b0;
         rdValid_q  <= 1'b0;
         accVal_q   <= '0;
         maxQ_q     <= '0;
`ifdef MAX_Q_SCHED_ARGMAX_EN
         runIdx_q   <= '0;
         bestIdx_q  <= '0;
`endif
      end else begin
         fsmState_q <= fsmState_d;
         latState_q <= latState_d;
         issueCnt_q <= issueCnt_d;
         recvCnt_q  <= recvCnt_d;
         first_q    <= first_d;
         rdValid_q  <= q_rd_en;
         accVal_q   <= accVal_d;
         maxQ_q     <= maxQ_d;
`ifdef MAX_Q_SCHED_ARGMAX_EN
         runIdx_q   <= runIdx_d;
         bestIdx_q  <= bestIdx_d;
`endif
      end
   end

endmodule
